// File: rtl/uart_tx_fifo_if.sv
// Byte-strobe side of the buffered UART transmitter: write strobe and data
// from the pipeline, FIFO status and the serial line back.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    pi_data;
    logic          pi_flag;
    logic          fifo_full;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic          busy;
    logic          tx;

    // Producer side: the pipeline writing bytes and watching status.
    modport master (
        output pi_data,
        output pi_flag,
        input  fifo_full,
        input  fifo_cnt,
        input  overflow,
        input  busy,
        input  tx
    );

    // Transmitter side.
    modport slave (
        input  pi_data,
        input  pi_flag,
        output fifo_full,
        output fifo_cnt,
        output overflow,
        output busy,
        output tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a FIFO_DEPTH-byte queue feeding an LSB-first
// serialiser. Frames from the queue run back to back with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_tx_fifo_if.slave bus
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, ovf_q;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          wr_ok_s, pop_s, not_empty_s, baud_end_s;

    // Write acceptance looks only at the pre-edge count, so a same-cycle pop
    // never makes room for the write.
    assign wr_ok_s     = bus.pi_flag && (cnt_q < DEPTH_C);
    assign not_empty_s = (cnt_q != {CW{1'b0}});
    assign baud_end_s  = (baud_q == BAUD_LAST);

    // Queue storage: data is captured only on an accepted write.
    always_ff @(posedge sys_clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= bus.pi_data;
        end
    end

    // Queue pointers, occupancy and status flags.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == DEPTH_C);
            ovf_q  <= bus.pi_flag && !wr_ok_s;
        end
    end

    // Occupancy next value; write plus pop together leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_ok_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Frame state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: start, eight data bits, stop, then chain or idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (not_empty_s) state_d = S_START;
                else             state_d = S_IDLE;
            end
            S_START: begin
                if (baud_end_s) state_d = S_DATA;
                else            state_d = S_START;
            end
            S_DATA: begin
                if (baud_end_s && (bit_q == 3'd7)) state_d = S_STOP;
                else                               state_d = S_DATA;
            end
            S_STOP: begin
                if (baud_end_s) begin
                    if (not_empty_s) state_d = S_START;
                    else             state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state datapath: pops, baud/bit counters and the next line level.
    always_comb begin
        pop_s  = 1'b0;
        tx_d   = tx_q;
        baud_d = baud_q + BW'(1'b1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        case (state_q)
            S_IDLE: begin
                baud_d = {BW{1'b0}};
                if (not_empty_s) begin
                    pop_s = 1'b1;
                    sh_d  = mem_q[rd_ptr_q];
                    tx_d  = 1'b0;
                end else begin
                    tx_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    bit_d  = 3'd0;
                    tx_d   = sh_q[0];
                end else begin
                    tx_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[bit_q + 3'd1];
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (not_empty_s) begin
                        pop_s = 1'b1;
                        sh_d  = mem_q[rd_ptr_q];
                        tx_d  = 1'b0;
                    end else begin
                        tx_d  = 1'b1;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                baud_d = {BW{1'b0}};
                tx_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Serialiser registers; reset drops any frame in flight with tx high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            baud_q <= {BW{1'b0}};
            bit_q  <= 3'd0;
            sh_q   <= 8'd0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_cnt  = cnt_q;
    assign bus.fifo_full = full_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level model (byte queue plus position in the
// current 50-cycle frame) checked every cycle, a UART receiver on tx, and
// directed scenarios with hand-computed expectations, then random traffic.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 50_000;
    localparam int UART_BPS = 9600;
    localparam int DEPTH    = 16;
    localparam int B        = 5;
    localparam int FRAME    = 10 * B;

    logic sys_clk = 1'b0;
    logic sys_rst;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by each rising edge.
    logic       s_rst  = 1'b0;
    logic       s_flag = 1'b0;
    logic [7:0] s_data = 8'd0;
    bit         s_seen = 1'b0;
    always @(posedge sys_clk) begin
        s_rst  <= sys_rst;
        s_flag <= bus.pi_flag;
        s_data <= bus.pi_data;
        s_seen <= 1'b1;
    end

    // Model state: queued bytes, bytes put on the line, current frame.
    logic [7:0] q_m[$];
    logic [7:0] sent_m[$];
    bit         act_m = 1'b0;
    logic [7:0] cur_m = 8'd0;
    int         t_m   = 0;
    bit         ovf_m = 1'b0;
    bit         model_ok = 1'b0;
    int         pre;
    bit         accept;

    // Receiver state and logs.
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = 8'd0;
    logic [7:0] rx_bytes[$];
    int         falls[$];
    int         cyc = 0;

    function automatic logic exp_tx();
        if (!act_m)        return 1'b1;
        if (t_m < B)       return 1'b0;
        if (t_m < 9 * B)   return cur_m[(t_m - B) / B];
        return 1'b1;
    endfunction

    // Advance the model by the edge just past, compare, then run the receiver.
    always @(negedge sys_clk) begin
        cyc++;
        if (s_seen) begin
            if (s_rst) begin
                q_m.delete();
                sent_m.delete();
                act_m    = 1'b0;
                t_m      = 0;
                ovf_m    = 1'b0;
                model_ok = 1'b1;
                rx_busy  = 1'b0;
                rx_t     = 0;
            end else begin
                pre    = q_m.size();
                accept = s_flag && (pre < DEPTH);
                if (act_m) begin
                    t_m++;
                    if (t_m == FRAME) begin
                        t_m = 0;
                        if (pre > 0) begin
                            cur_m = q_m.pop_front();
                            sent_m.push_back(cur_m);
                        end else begin
                            act_m = 1'b0;
                        end
                    end
                end else if (pre > 0) begin
                    cur_m = q_m.pop_front();
                    sent_m.push_back(cur_m);
                    act_m = 1'b1;
                    t_m   = 0;
                end
                if (accept) q_m.push_back(s_data);
                ovf_m = s_flag && !accept;
            end
            if (model_ok) begin
                check("tx", bus.tx, exp_tx());
                check("busy", bus.busy, act_m);
                check("fifo_cnt", bus.fifo_cnt, q_m.size());
                check("fifo_full", bus.fifo_full, q_m.size() == DEPTH);
                check("overflow", bus.overflow, ovf_m);
            end
            if (model_ok && !s_rst) begin
                if (!rx_busy) begin
                    if (bus.tx == 1'b0) begin
                        rx_busy = 1'b1;
                        rx_t    = 0;
                        falls.push_back(cyc);
                    end
                end else begin
                    rx_t++;
                    if (rx_t >= B + 2 && rx_t < 9 * B + 2 && ((rx_t - B - 2) % B) == 0)
                        rx_sh[(rx_t - B - 2) / B] = bus.tx;
                    if (rx_t == 9 * B + 2) begin
                        check("rx_stop_bit", bus.tx, 1'b1);
                        rx_bytes.push_back(rx_sh);
                        if (sent_m.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL rx_unexpected: got byte %0h, expected no frame", rx_sh);
                        end else begin
                            check("rx_byte", rx_sh, sent_m.pop_front());
                        end
                    end
                    if (rx_t == FRAME - 1) rx_busy = 1'b0;
                end
            end
        end
    end

    logic [9:0] frame_v;
    int         busy_n;
    int         peak;
    int         low_n;
    int         rate;

    initial begin
        sys_rst     = 1'b1;
        bus.pi_flag = 1'b0;
        bus.pi_data = 8'd0;

        // Reset held with pi_flag toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("rst_tx", bus.tx, 1'b1);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_cnt", bus.fifo_cnt, 32'd0);
            check("rst_ovf", bus.overflow, 1'b0);
            bus.pi_flag = ~bus.pi_flag;
        end
        @(negedge sys_clk);
        check("rst_tx_end", bus.tx, 1'b1);
        check("rst_cnt_end", bus.fifo_cnt, 32'd0);
        sys_rst     = 1'b0;
        bus.pi_flag = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Single byte 0xA5: start, LSB-first data, stop, 5 cycles each.
        frame_v     = {1'b1, 8'hA5, 1'b0};
        busy_n      = 0;
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'hA5;
        @(negedge sys_clk);
        bus.pi_flag = 1'b0;
        check("single_pending_cnt", bus.fifo_cnt, 32'd1);
        check("single_not_started", bus.tx, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge sys_clk);
            check("single_tx", bus.tx, frame_v[k / B]);
            if (bus.busy) busy_n++;
        end
        @(negedge sys_clk);
        check("single_busy_cycles", busy_n, 32'd50);
        check("single_busy_fall", bus.busy, 1'b0);
        repeat (10) @(negedge sys_clk);

        // Burst of three bytes on consecutive cycles.
        rx_bytes.delete();
        falls.delete();
        peak = 0;
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'h00;
        @(negedge sys_clk);
        bus.pi_data = 8'hFF;
        @(negedge sys_clk);
        bus.pi_data = 8'h3C;
        @(negedge sys_clk);
        bus.pi_flag = 1'b0;
        for (int k = 0; k < 170; k++) begin
            if (int'(bus.fifo_cnt) > peak) peak = int'(bus.fifo_cnt);
            @(negedge sys_clk);
        end
        check("burst_peak_cnt", peak, 32'd2);
        check("burst_frames", falls.size(), 32'd3);
        if (falls.size() == 3) begin
            check("burst_gap1", falls[1] - falls[0], 32'd50);
            check("burst_gap2", falls[2] - falls[1], 32'd50);
        end
        check("burst_rx_n", rx_bytes.size(), 32'd3);
        if (rx_bytes.size() == 3) begin
            check("burst_rx0", rx_bytes[0], 8'h00);
            check("burst_rx1", rx_bytes[1], 8'hFF);
            check("burst_rx2", rx_bytes[2], 8'h3C);
        end

        // Fill to full, overflow on the 18th write, then write on the pop edge.
        rx_bytes.delete();
        for (int i = 0; i < 18; i++) begin
            bus.pi_flag = 1'b1;
            bus.pi_data = 8'(i + 1);
            @(negedge sys_clk);
        end
        bus.pi_flag = 1'b0;
        check("full_flag", bus.fifo_full, 1'b1);
        check("full_cnt", bus.fifo_cnt, 32'd16);
        check("full_ovf_pulse", bus.overflow, 1'b1);
        @(negedge sys_clk);
        check("full_ovf_one_cycle", bus.overflow, 1'b0);
        repeat (32) @(negedge sys_clk);
        check("popedge_pre_cnt", bus.fifo_cnt, 32'd16);
        check("popedge_pre_full", bus.fifo_full, 1'b1);
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'h99;
        @(negedge sys_clk);
        bus.pi_flag = 1'b0;
        check("popedge_ovf", bus.overflow, 1'b1);
        check("popedge_cnt", bus.fifo_cnt, 32'd15);
        check("popedge_full", bus.fifo_full, 1'b0);
        repeat (17 * FRAME + 50) @(negedge sys_clk);
        check("full_rx_n", rx_bytes.size(), 32'd17);
        if (rx_bytes.size() == 17) begin
            for (int i = 0; i < 17; i++) check("full_rx_seq", rx_bytes[i], 8'(i + 1));
        end

        // Reset during data bit 3 of 0x55 with four bytes queued.
        rx_bytes.delete();
        for (int i = 0; i < 5; i++) begin
            bus.pi_flag = 1'b1;
            bus.pi_data = (i == 0) ? 8'h55 : 8'(8'h11 * i);
            @(negedge sys_clk);
        end
        bus.pi_flag = 1'b0;
        repeat (18) @(negedge sys_clk);
        check("midrst_bit3", bus.tx, 1'b0);
        check("midrst_queued", bus.fifo_cnt, 32'd4);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_tx", bus.tx, 1'b1);
        check("midrst_cnt", bus.fifo_cnt, 32'd0);
        check("midrst_busy", bus.busy, 1'b0);
        sys_rst = 1'b0;
        low_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (bus.tx == 1'b0 || bus.busy) low_n++;
        end
        check("midrst_quiet", low_n, 32'd0);
        check("midrst_no_rx", rx_bytes.size(), 32'd0);
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'hC3;
        @(negedge sys_clk);
        bus.pi_flag = 1'b0;
        repeat (FRAME + 10) @(negedge sys_clk);
        check("midrst_new_rx_n", rx_bytes.size(), 32'd1);
        if (rx_bytes.size() == 1) check("midrst_new_rx", rx_bytes[0], 8'hC3);

        // Random traffic: sparse, then dense enough to hit full and overflow.
        for (int k = 0; k < 3000; k++) begin
            rate        = (k < 1500) ? 3 : 40;
            bus.pi_flag = ($urandom_range(0, 99) < rate);
            bus.pi_data = 8'($urandom);
            sys_rst     = ($urandom_range(0, 999) == 0);
            @(negedge sys_clk);
        end
        bus.pi_flag = 1'b0;
        sys_rst     = 1'b0;
        repeat (17 * FRAME + 60) @(negedge sys_clk);
        check("drain_cnt", bus.fifo_cnt, 32'd0);
        check("drain_busy", bus.busy, 1'b0);
        check("drain_tx", bus.tx, 1'b1);
        check("drain_all_received", sent_m.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
